wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the ARMv8 pipeline: the MEM/WB pipeline register plus write-back data selection, driving the register file's single write port (`RegWrite`, `WriteReg`, `WriteData`). It captures one retiring instruction per cycle from the memory stage and load-extends memory data. It holds results in a 2-entry in-order buffer while the RF write port is busy, and answers forwarding queries so decode/execute can bypass values not yet written.

## Interface
Parameters:
- `DW`, 64, datapath width
- `AW`, 5, register index width (register 31 = XZR)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `Reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  memory stage presents an instruction
- `in_ready`  out  1  stage can accept this cycle
- `in_rd`  in  AW  destination register
- `in_reg_write`  in  1  instruction writes a register
- `in_mem_to_reg`  in  1  result is load data
- `in_link`  in  1  result is `in_pc`+4 (BL/BLR)
- `in_ld_size`  in  2  00 byte, 01 half, 10 word, 11 dword
- `in_ld_signed`  in  1  sign-extend load data
- `in_alu_result`  in  DW  ALU result
- `in_mem_data`  in  DW  raw load data (little-endian, bits [7:0] = lowest byte)
- `in_pc`  in  DW  instruction address
- `flush`  in  1  kill all buffered, unwritten instructions
- `rf_busy`  in  1  RF write port unavailable this cycle
- `RegWrite`  out  1  RF write enable
- `WriteReg`  out  AW  RF write index
- `WriteData`  out  DW  RF write data
- `fwd_q_rd`  in  AW  forwarding query register
- `fwd_hit`  out  1  a buffered instruction will write `fwd_q_rd`
- `fwd_data`  out  DW  value for `fwd_q_rd` (youngest match)
- `retired_count`  out  64  retired instructions (only with `WB_RETIRE_CNT_EN`)

## Operation
- Two entries, S (head, drives RF port) and K (skid, younger). Each holds valid, we, rd, and final data.
- Data is resolved at capture. Priority: link → `in_pc`+4 (mod 2^64); else mem_to_reg → extended load; else `in_alu_result`.
- Load extension:
  - Byte, half and word take bits [7:0], [15:0] and [31:0], zero- or sign-extended per `in_ld_signed`.
  - Dword passes through unchanged, ignoring `in_ld_signed`.
- Entry we = `in_reg_write` & (`in_rd` != 31). Writes to XZR are discarded, but the instruction still retires.
- `in_ready` = !K.valid & !Reset.
- Retire occurs when S.valid & !`rf_busy`.
- `RegWrite` = S.valid & S.we & !`rf_busy`. `WriteReg`/`WriteData` = S.rd/S.data when S.valid, else 0.
- Per-edge update, given accept = `in_valid` & `in_ready`:
  - S empty or retiring, K valid: K→S, and accept (if any) loads K.
  - S empty or retiring, K empty: accept loads S.
  - S held (valid & `rf_busy`): accept loads K.
- Order is strictly preserved; no entry overtakes another.
- `flush` clears S.valid and K.valid at the edge and drops any simultaneous accept. The current-cycle RF write (if `RegWrite` high) still occurs.
- Forwarding is combinational:
  - `fwd_hit` = (K.valid & K.we & K.rd==`fwd_q_rd`) | (S.valid & S.we & S.rd==`fwd_q_rd`).
  - `fwd_data` = K.data if K matches, else S.data if S matches, else 0.
  - Query 31 never hits.

## Timing
- Reset: S/K invalid, `RegWrite`=0, `WriteReg`=0, `WriteData`=0, `in_ready`=0 while `Reset` high and 1 on the first cycle after, `fwd_hit`=0, `fwd_data`=0, `retired_count`=0.
- Latency: instruction accepted at edge N drives `RegWrite` during cycle N..N+1 and is written to RF at edge N+1 (if `rf_busy` low).
- Throughput: 1/cycle while `rf_busy` low. `in_ready` drops the cycle after K fills and rises the cycle after K drains.
- `rf_busy` held indefinitely: S and K stay intact, `in_ready`=0, forwarding remains valid.
- `Reset` mid-operation discards S/K without further RF writes (`RegWrite` forced 0 while `Reset` high).
- `flush` and `Reset` together: reset wins; the result is identical.

## Configuration
- `WB_RETIRE_CNT_EN` defined:
  - `retired_count` port exists.
  - The 64-bit counter increments by 1 on each retire edge, including XZR and non-writing instructions, and wraps at 2^64.
  - The counter is not cleared by `flush`.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- ALU op: rd=5, alu=0x1234, `rf_busy`=0 → next cycle `RegWrite`=1, `WriteReg`=5, `WriteData`=0x1234. Back-to-back stream of 8 sustains 1/cycle with `in_ready` always 1.
- Loads with `in_mem_data`=0x...80FF_80F0_8081_F080:
  - Signed byte → 0xFFFF_FFFF_FFFF_FF80; unsigned half → 0x0000_0000_0000_F080.
  - Signed word → 0xFFFF_FFFF_8081_F080; dword signed → raw value.
- BL: `in_link`=1, `in_pc`=0x400, rd=30 → `WriteData`=0x404. XZR write: rd=31, `in_reg_write`=1 → `RegWrite` stays 0, instruction still counted.
- `rf_busy` held 3 cycles with 3 inputs offered: the first two are buffered, `in_ready`=0 during the hold. On release the writes occur in order, one per cycle, with no loss. `fwd_q_rd` matching both S and K returns K's data.
- `flush` with S and K full and a simultaneous `in_valid`: no further RF writes, `fwd_hit`=0 next cycle, `in_ready`=1.
- `Reset` asserted mid-stream with `rf_busy`=0: `RegWrite`=0 during reset, all outputs 0 afterwards, and `retired_count`=0 with the macro defined.

Source files
------------

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Purpose  : Write-back stage. Holds the MEM/WB pipeline register and a
//            two-entry in-order buffer (S = head, K = skid). It resolves the
//            write-back value when an instruction is captured: link PC+4,
//            load-extended memory data, or the ALU result. It drives the
//            register file's single write port and answers combinational
//            forwarding queries for values that are not yet written.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: WB_RETIRE_CNT_EN
//   Defined   -> 64-bit retired-instruction counter on port retired_count.
//   Undefined -> counter and port are absent.
// ----------------------------------------------------------------------------
// Parameters
//   DW : datapath width (64)
//   AW : register index width (5, register 31 = XZR)
// Ports
//   clk, Reset            : clock, synchronous active-high reset
//   in_valid / in_ready   : capture handshake with the memory stage
//   in_rd, in_reg_write   : destination register and its write enable
//   in_mem_to_reg, in_link: result source select (link has top priority)
//   in_ld_size, in_ld_signed : load width (B/H/W/D) and sign extension
//   in_alu_result, in_mem_data, in_pc : candidate result sources
//   flush                 : drop every buffered, unwritten instruction
//   rf_busy               : RF write port unavailable this cycle
//   RegWrite, WriteReg, WriteData : RF write port
//   fwd_q_rd -> fwd_hit, fwd_data : forwarding query (youngest match)
//   retired_count         : retired instruction count (macro only)
// ============================================================================
module wb_stage #(
  parameter int DW = 64,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rd,
  input  logic          in_reg_write,
  input  logic          in_mem_to_reg,
  input  logic          in_link,
  input  logic [1:0]    in_ld_size,
  input  logic          in_ld_signed,
  input  logic [DW-1:0] in_alu_result,
  input  logic [DW-1:0] in_mem_data,
  input  logic [DW-1:0] in_pc,
  input  logic          flush,
  input  logic          rf_busy,
  output logic          RegWrite,
  output logic [AW-1:0] WriteReg,
  output logic [DW-1:0] WriteData,
  input  logic [AW-1:0] fwd_q_rd,
  output logic          fwd_hit,
  output logic [DW-1:0] fwd_data
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]   retired_count
`endif
);

  localparam logic [AW-1:0] c_XZR      = AW'(31);
  localparam logic [DW-1:0] c_LINK_INC = DW'(4);
  localparam logic [1:0]    c_SZ_BYTE  = 2'b00;
  localparam logic [1:0]    c_SZ_HALF  = 2'b01;
  localparam logic [1:0]    c_SZ_WORD  = 2'b10;

  // --------------------------------------------------------------------------
  // Buffer entries
  // --------------------------------------------------------------------------
  logic          r_s_valid;
  logic          r_s_we;
  logic [AW-1:0] r_s_rd;
  logic [DW-1:0] r_s_data;

  logic          r_k_valid;
  logic          r_k_we;
  logic [AW-1:0] r_k_rd;
  logic [DW-1:0] r_k_data;

  // --------------------------------------------------------------------------
  // Capture-side combinational logic
  // --------------------------------------------------------------------------
  logic [DW-1:0] w_ld_ext;
  logic [DW-1:0] w_cap_data;
  logic          w_cap_we;
  logic          w_accept;
  logic          w_retire;
  logic          w_s_free;

  // Load extension: narrow loads take the low bytes and replicate either
  // zero or the narrow sign bit; dword ignores the signed flag entirely.
  always_comb begin
    w_ld_ext = in_mem_data;
    case (in_ld_size)
      c_SZ_BYTE: w_ld_ext = {{(DW-8){in_ld_signed & in_mem_data[7]}},
                             in_mem_data[7:0]};
      c_SZ_HALF: w_ld_ext = {{(DW-16){in_ld_signed & in_mem_data[15]}},
                             in_mem_data[15:0]};
      c_SZ_WORD: w_ld_ext = {{(DW-32){in_ld_signed & in_mem_data[31]}},
                             in_mem_data[31:0]};
      default:   w_ld_ext = in_mem_data;
    endcase
  end

  // Result priority: link, then load data, then ALU result.
  always_comb begin
    w_cap_data = in_alu_result;
    if (in_link) begin
      w_cap_data = in_pc + c_LINK_INC;
    end else if (in_mem_to_reg) begin
      w_cap_data = w_ld_ext;
    end
  end

  // XZR writes are suppressed here so that neither the RF port nor the
  // forwarding path ever sees them; the instruction still occupies a slot
  // and still retires.
  assign w_cap_we = in_reg_write & (in_rd != c_XZR);

  assign in_ready = ~r_k_valid & ~Reset;
  assign w_accept = in_valid & in_ready;
  assign w_retire = r_s_valid & ~rf_busy;
  // S can take new contents at this edge if it is empty or leaving.
  assign w_s_free = ~r_s_valid | w_retire;

  // --------------------------------------------------------------------------
  // RF write port
  // --------------------------------------------------------------------------
  assign RegWrite  = r_s_valid & r_s_we & ~rf_busy & ~Reset;
  assign WriteReg  = r_s_valid ? r_s_rd   : '0;
  assign WriteData = r_s_valid ? r_s_data : '0;

  // --------------------------------------------------------------------------
  // Forwarding: K is younger than S, so K wins when both match. Entries
  // carrying XZR have we cleared, so a query for 31 can never hit.
  // --------------------------------------------------------------------------
  logic w_k_match;
  logic w_s_match;

  assign w_k_match = r_k_valid & r_k_we & (r_k_rd == fwd_q_rd);
  assign w_s_match = r_s_valid & r_s_we & (r_s_rd == fwd_q_rd);
  assign fwd_hit   = w_k_match | w_s_match;

  always_comb begin
    fwd_data = '0;
    if (w_k_match) begin
      fwd_data = r_k_data;
    end else if (w_s_match) begin
      fwd_data = r_s_data;
    end
  end

  // --------------------------------------------------------------------------
  // Buffer update
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_s_valid <= 1'b0;
      r_s_we    <= 1'b0;
      r_s_rd    <= '0;
      r_s_data  <= '0;
      r_k_valid <= 1'b0;
      r_k_we    <= 1'b0;
      r_k_rd    <= '0;
      r_k_data  <= '0;
    end else if (flush) begin
      // The write of the current head (if RegWrite is high) has already
      // happened at this edge on the RF side; only the buffer is emptied.
      r_s_valid <= 1'b0;
      r_k_valid <= 1'b0;
    end else if (w_s_free) begin
      if (r_k_valid) begin
        // Older skid entry advances to head; a new capture refills K.
        r_s_valid <= 1'b1;
        r_s_we    <= r_k_we;
        r_s_rd    <= r_k_rd;
        r_s_data  <= r_k_data;
        r_k_valid <= w_accept;
        if (w_accept) begin
          r_k_we   <= w_cap_we;
          r_k_rd   <= in_rd;
          r_k_data <= w_cap_data;
        end
      end else begin
        r_s_valid <= w_accept;
        if (w_accept) begin
          r_s_we   <= w_cap_we;
          r_s_rd   <= in_rd;
          r_s_data <= w_cap_data;
        end
      end
    end else if (w_accept) begin
      // Head is stalled by rf_busy; in_ready guarantees K is empty here.
      r_k_valid <= 1'b1;
      r_k_we    <= w_cap_we;
      r_k_rd    <= in_rd;
      r_k_data  <= w_cap_data;
    end
  end

  // --------------------------------------------------------------------------
  // Optional retire counter (not cleared by flush; wraps naturally)
  // --------------------------------------------------------------------------
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] r_retired_count;

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_retired_count <= '0;
    end else if (w_retire) begin
      r_retired_count <= r_retired_count + 64'd1;
    end
  end

  assign retired_count = r_retired_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage
// Purpose  : Self-checking bench for wb_stage. A queue-based model of the
//            in-order write-back buffer is compared against the DUT on every
//            falling edge; directed scenarios add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

  localparam int DW = 64;
  localparam int AW = 5;

  logic          clk;
  logic          Reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rd;
  logic          in_reg_write;
  logic          in_mem_to_reg;
  logic          in_link;
  logic [1:0]    in_ld_size;
  logic          in_ld_signed;
  logic [DW-1:0] in_alu_result;
  logic [DW-1:0] in_mem_data;
  logic [DW-1:0] in_pc;
  logic          flush;
  logic          rf_busy;
  logic          RegWrite;
  logic [AW-1:0] WriteReg;
  logic [DW-1:0] WriteData;
  logic [AW-1:0] fwd_q_rd;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0]   retired_count;
`endif

  wb_stage #(.DW(DW), .AW(AW)) u_dut (
    .clk          (clk),
    .Reset        (Reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rd        (in_rd),
    .in_reg_write (in_reg_write),
    .in_mem_to_reg(in_mem_to_reg),
    .in_link      (in_link),
    .in_ld_size   (in_ld_size),
    .in_ld_signed (in_ld_signed),
    .in_alu_result(in_alu_result),
    .in_mem_data  (in_mem_data),
    .in_pc        (in_pc),
    .flush        (flush),
    .rf_busy      (rf_busy),
    .RegWrite     (RegWrite),
    .WriteReg     (WriteReg),
    .WriteData    (WriteData),
    .fwd_q_rd     (fwd_q_rd),
    .fwd_hit      (fwd_hit),
    .fwd_data     (fwd_data)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retired_count(retired_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit en      = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
  endtask

  // --------------------------------------------------------------------------
  // Reference model: an ordered list of pending writes, at most two deep.
  // --------------------------------------------------------------------------
  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [63:0] d;
  } ent_t;

  ent_t        q[$];
  logic [63:0] m_cnt = 64'd0;

  function automatic logic [63:0] resolve();
    int          nbits;
    logic [63:0] mask;
    logic [63:0] v;
    if (in_link) return in_pc + 64'd4;
    if (!in_mem_to_reg) return in_alu_result;
    if (in_ld_size == 2'b11) return in_mem_data;
    nbits = 8 << in_ld_size;
    mask  = (64'd1 << nbits) - 64'd1;
    v     = in_mem_data & mask;
    if (in_ld_signed && in_mem_data[nbits-1]) v = v | ~mask;
    return v;
  endfunction

  always @(negedge clk) begin
    if (en) begin
      logic        e_ready, e_rw, e_hit, acc;
      logic [4:0]  e_reg;
      logic [63:0] e_wd, e_fd;
      ent_t        n;
      e_ready = !Reset && (q.size() < 2);
      e_rw    = (q.size() > 0) && q[0].we && !rf_busy && !Reset;
      e_reg   = (q.size() > 0) ? q[0].rd : 5'd0;
      e_wd    = (q.size() > 0) ? q[0].d  : 64'd0;
      e_hit   = 1'b0;
      e_fd    = 64'd0;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (!e_hit && q[i].we && q[i].rd == fwd_q_rd) begin
          e_hit = 1'b1;
          e_fd  = q[i].d;
        end
      end
      chk("m_in_ready",  {63'd0, in_ready}, {63'd0, e_ready});
      chk("m_RegWrite",  {63'd0, RegWrite}, {63'd0, e_rw});
      chk("m_WriteReg",  {59'd0, WriteReg}, {59'd0, e_reg});
      chk("m_WriteData", WriteData, e_wd);
      chk("m_fwd_hit",   {63'd0, fwd_hit},  {63'd0, e_hit});
      chk("m_fwd_data",  fwd_data, e_fd);
`ifdef WB_RETIRE_CNT_EN
      chk("m_retired_count", retired_count, m_cnt);
`endif
      // Advance the model to the state after the coming rising edge.
      acc = in_valid && e_ready;
      if (Reset) begin
        q.delete();
        m_cnt = 64'd0;
      end else begin
        if (q.size() > 0 && !rf_busy) begin
          void'(q.pop_front());
          m_cnt = m_cnt + 64'd1;
        end
        if (flush) begin
          q.delete();
        end else if (acc) begin
          n.we = in_reg_write && (in_rd != 5'd31);
          n.rd = in_rd;
          n.d  = resolve();
          q.push_back(n);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  localparam logic [63:0] c_MEM = 64'h80FF_80F0_8081_F080;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid      = 1'b0;
    in_reg_write  = 1'b0;
    in_mem_to_reg = 1'b0;
    in_link       = 1'b0;
    in_ld_size    = 2'b00;
    in_ld_signed  = 1'b0;
    in_rd         = 5'd0;
    in_alu_result = 64'd0;
    in_mem_data   = 64'd0;
    in_pc         = 64'd0;
  endtask

  task automatic drive(input logic [4:0] rd, input logic rw, input logic m2r,
                       input logic lnk, input logic [1:0] sz, input logic sgn,
                       input logic [63:0] alu, input logic [63:0] mem,
                       input logic [63:0] pc);
    in_valid      = 1'b1;
    in_rd         = rd;
    in_reg_write  = rw;
    in_mem_to_reg = m2r;
    in_link       = lnk;
    in_ld_size    = sz;
    in_ld_signed  = sgn;
    in_alu_result = alu;
    in_mem_data   = mem;
    in_pc         = pc;
  endtask

  task automatic ld_check(input string name, input logic [1:0] sz,
                          input logic sgn, input logic [63:0] exp);
    drive(5'd9, 1'b1, 1'b1, 1'b0, sz, sgn, 64'hDEAD_BEEF, c_MEM, 64'h0);
    step();
    idle();
    @(negedge clk);
    chk(name, WriteData, exp);
    step();
  endtask

  // --------------------------------------------------------------------------
  // Directed scenarios
  // --------------------------------------------------------------------------
  initial begin
    Reset    = 1'b1;
    flush    = 1'b0;
    rf_busy  = 1'b0;
    fwd_q_rd = 5'd5;
    idle();
    step();
    en = 1'b1;
    step();

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_RegWrite", {63'd0, RegWrite}, 64'd0);
    chk("rst_WriteData", WriteData, 64'd0);
    step();
    Reset = 1'b0;
    #1;
    chk("ready_after_rst", {63'd0, in_ready}, 64'd1);

    // Single ALU op
    drive(5'd5, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 64'h1234, 64'h0, 64'h0);
    step();
    idle();
    @(negedge clk);
    chk("alu_RegWrite", {63'd0, RegWrite}, 64'd1);
    chk("alu_WriteReg", {59'd0, WriteReg}, 64'd5);
    chk("alu_WriteData", WriteData, 64'h1234);
    chk("alu_fwd_data", fwd_data, 64'h1234);
    step();

    // Back-to-back stream of 8
    for (int i = 0; i < 8; i++) begin
      drive(5'(i + 1), 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 64'(i) * 64'h1111, 64'h0, 64'h0);
      @(negedge clk);
      chk("stream_ready", {63'd0, in_ready}, 64'd1);
      step();
    end
    idle();
    step();

    // Load extension
    ld_check("ld_sbyte", 2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FF80);
    ld_check("ld_ubyte", 2'b00, 1'b0, 64'h0000_0000_0000_0080);
    ld_check("ld_uhalf", 2'b01, 1'b0, 64'h0000_0000_0000_F080);
    ld_check("ld_shalf", 2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_F080);
    ld_check("ld_sword", 2'b10, 1'b1, 64'hFFFF_FFFF_8081_F080);
    ld_check("ld_uword", 2'b10, 1'b0, 64'h0000_0000_8081_F080);
    ld_check("ld_dword", 2'b11, 1'b1, 64'h80FF_80F0_8081_F080);

    // BL: link beats mem_to_reg
    drive(5'd30, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 64'h99, c_MEM, 64'h400);
    step();
    idle();
    @(negedge clk);
    chk("bl_WriteData", WriteData, 64'h404);
    chk("bl_WriteReg", {59'd0, WriteReg}, 64'd30);
    step();

    // XZR write
    fwd_q_rd = 5'd31;
    drive(5'd31, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 64'h55, 64'h0, 64'h0);
    step();
    idle();
    @(negedge clk);
    chk("xzr_RegWrite", {63'd0, RegWrite}, 64'd0);
    chk("xzr_fwd_hit", {63'd0, fwd_hit}, 64'd0);
    step();

    // rf_busy hold with three offers
    rf_busy = 1'b1;
    fwd_q_rd = 5'd7;
    drive(5'd7, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 64'hA1, 64'h0, 64'h0);
    step();
    drive(5'd7, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 64'hB2, 64'h0, 64'h0);
    step();
    drive(5'd8, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 64'hC3, 64'h0, 64'h0);
    @(negedge clk);
    chk("hold_ready0", {63'd0, in_ready}, 64'd0);
    step();
    @(negedge clk);
    chk("hold_ready1", {63'd0, in_ready}, 64'd0);
    chk("hold_fwd_hit", {63'd0, fwd_hit}, 64'd1);
    chk("hold_fwd_youngest", fwd_data, 64'hB2);
    chk("hold_RegWrite", {63'd0, RegWrite}, 64'd0);
    step();
    rf_busy = 1'b0;
    @(negedge clk);
    chk("rel_first", WriteData, 64'hA1);
    step();
    @(negedge clk);
    chk("rel_second", WriteData, 64'hB2);
    chk("rel_ready", {63'd0, in_ready}, 64'd1);
    step();
    idle();
    @(negedge clk);
    chk("rel_third", WriteData, 64'hC3);
    chk("rel_third_reg", {59'd0, WriteReg}, 64'd8);
    step();

    // Flush with S and K full and a simultaneous offer
    rf_busy = 1'b1;
    fwd_q_rd = 5'd11;
    drive(5'd10, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 64'h10, 64'h0, 64'h0);
    step();
    drive(5'd11, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 64'h11, 64'h0, 64'h0);
    step();
    rf_busy = 1'b0;
    flush   = 1'b1;
    drive(5'd12, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 64'h12, 64'h0, 64'h0);
    @(negedge clk);
    chk("flush_cur_write", {63'd0, RegWrite}, 64'd1);
    step();
    flush = 1'b0;
    idle();
    @(negedge clk);
    chk("flush_fwd_hit", {63'd0, fwd_hit}, 64'd0);
    chk("flush_ready", {63'd0, in_ready}, 64'd1);
    chk("flush_no_write", {63'd0, RegWrite}, 64'd0);
    step();

    // Reset mid-stream
    fwd_q_rd = 5'd14;
    for (int i = 0; i < 3; i++) begin
      drive(5'(13 + i), 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 64'h100 + 64'(i), 64'h0, 64'h0);
      step();
    end
    Reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_RegWrite0", {63'd0, RegWrite}, 64'd0);
    step();
    @(negedge clk);
    chk("rst_mid_RegWrite1", {63'd0, RegWrite}, 64'd0);
    step();
    Reset = 1'b0;
    idle();
    @(negedge clk);
    chk("rst_mid_WriteData", WriteData, 64'd0);
    chk("rst_mid_fwd_hit", {63'd0, fwd_hit}, 64'd0);
    chk("rst_mid_ready", {63'd0, in_ready}, 64'd1);
`ifdef WB_RETIRE_CNT_EN
    chk("rst_mid_count", retired_count, 64'd0);
`endif
    step();
    step();

    en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
